// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_par_en;
    logic [NUM_REQ-1:0]            req_par_typ;
    logic                          tx_busy;
    logic [NUM_REQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]         P_DATA;
    logic                          Data_valid;
    logic                          PAR_EN;
    logic                          PAR_TYP;
    logic [ID_W-1:0]               grant_id;
    logic                          arb_busy;
    logic                          err_timeout;

    modport slave (
        input  req, req_data, req_par_en, req_par_typ, tx_busy,
        output ack, P_DATA, Data_valid, PAR_EN, PAR_TYP, grant_id, arb_busy, err_timeout
    );

    modport master (
        output req, req_data, req_par_en, req_par_typ, tx_busy,
        input  ack, P_DATA, Data_valid, PAR_EN, PAR_TYP, grant_id, arb_busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Holds the granted byte and parity settings on the transmitter for the whole frame.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                 state;
    logic [ID_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]       cnt;

    logic                   win_vld;
    logic [ID_W-1:0]        win_id;
    logic [ID_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]  win_data;
    logic                   win_par_en;
    logic                   win_par_typ;

    // Scan downward in offset so the lowest offset from rr_ptr is the last writer.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (bus.req[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    always_comb begin
        win_data    = '0;
        win_par_en  = 1'b0;
        win_par_typ = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_data    = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_par_en  = bus.req_par_en[i];
                win_par_typ = bus.req_par_typ[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            cnt             <= '0;
            bus.ack         <= '0;
            bus.P_DATA      <= '0;
            bus.Data_valid  <= 1'b0;
            bus.PAR_EN      <= 1'b0;
            bus.PAR_TYP     <= 1'b0;
            bus.grant_id    <= '0;
            bus.arb_busy    <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.Data_valid  <= 1'b0;
            bus.ack         <= '0;
            bus.err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.tx_busy && win_vld) begin
                        bus.P_DATA     <= win_data;
                        bus.PAR_EN     <= win_par_en;
                        bus.PAR_TYP    <= win_par_typ;
                        bus.grant_id   <= win_id;
                        rr_ptr         <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
                        bus.Data_valid <= 1'b1;
                        bus.ack        <= NUM_REQ'(1) << win_id;
                        bus.arb_busy   <= 1'b1;
                        state          <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // The registered pulse lands BUSY_TIMEOUT cycles after the launch cycle.
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_W'(BUSY_TIMEOUT - 2)) begin
                        bus.err_timeout <= 1'b1;
                        bus.arb_busy    <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        bus.arb_busy <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    bus.arb_busy <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the transmitter's busy line is driven by hand.
module tb_uart_tx_arbiter;
    logic CLK;
    logic RST;
    int   checks = 0;
    int   passes = 0;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BUSY_TIMEOUT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_data = '0; bus.req_par_en = '0; bus.req_par_typ = '0; bus.tx_busy = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        checks++; if (bus.Data_valid !== 1'b0) $display("FAIL reset_dv: got %b want 0", bus.Data_valid); else passes++;
        checks++; if (bus.ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", bus.ack); else passes++;
        checks++; if (bus.P_DATA !== 8'h00) $display("FAIL reset_pdata: got %h want 00", bus.P_DATA); else passes++;
        checks++; if (bus.arb_busy !== 1'b0) $display("FAIL reset_arb_busy: got %b want 0", bus.arb_busy); else passes++;
        checks++; if (bus.grant_id !== 2'd0) $display("FAIL reset_grant: got %0d want 0", bus.grant_id); else passes++;
        checks++; if (bus.err_timeout !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err_timeout); else passes++;
        RST = 1'b0;
    endtask

    task automatic test_single();
        bus.req = 4'b0010;
        bus.req_data = 32'h0000_A500;
        bus.req_par_en = 4'b0010;
        bus.req_par_typ = 4'b0000;
        tick();
        checks++; if (bus.Data_valid !== 1'b1) $display("FAIL single_dv: got %b want 1", bus.Data_valid); else passes++;
        checks++; if (bus.ack !== 4'b0010) $display("FAIL single_ack: got %b want 0010", bus.ack); else passes++;
        checks++; if (bus.P_DATA !== 8'hA5) $display("FAIL single_pdata: got %h want a5", bus.P_DATA); else passes++;
        checks++; if (bus.PAR_EN !== 1'b1 || bus.PAR_TYP !== 1'b0) $display("FAIL single_parity: got en=%b typ=%b want en=1 typ=0", bus.PAR_EN, bus.PAR_TYP); else passes++;
        checks++; if (bus.grant_id !== 2'd1) $display("FAIL single_grant: got %0d want 1", bus.grant_id); else passes++;
        bus.req = '0;
        bus.req_data = '0;
        bus.tx_busy = 1'b1;
        tick();
        checks++; if (bus.Data_valid !== 1'b0 || bus.ack !== 4'b0000) $display("FAIL single_pulse_width: got dv=%b ack=%b want dv=0 ack=0000", bus.Data_valid, bus.ack); else passes++;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (bus.P_DATA !== 8'hA5 || bus.arb_busy !== 1'b1) $display("FAIL single_hold%0d: got pdata=%h busy=%b want a5/1", k, bus.P_DATA, bus.arb_busy); else passes++;
        end
        bus.tx_busy = 1'b0;
        tick();
        checks++; if (bus.arb_busy !== 1'b0) $display("FAIL single_release: got %b want 0", bus.arb_busy); else passes++;
        checks++; if (bus.P_DATA !== 8'hA5) $display("FAIL single_keep_pdata: got %h want a5", bus.P_DATA); else passes++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_byte [4];
        exp_byte[0] = 8'h10; exp_byte[1] = 8'h21; exp_byte[2] = 8'h32; exp_byte[3] = 8'h43;
        do_reset();
        bus.req = 4'b1111;
        bus.req_data = 32'h4332_2110;
        bus.req_par_en = 4'b0101;
        bus.req_par_typ = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.Data_valid !== 1'b1 || bus.ack !== (4'b0001 << k)) $display("FAIL rr_launch%0d: got dv=%b ack=%b want dv=1 ack=%b", k, bus.Data_valid, bus.ack, 4'b0001 << k); else passes++;
            checks++; if (bus.P_DATA !== exp_byte[k] || bus.grant_id !== 2'(k)) $display("FAIL rr_data%0d: got %h id=%0d want %h id=%0d", k, bus.P_DATA, bus.grant_id, exp_byte[k], k); else passes++;
            checks++; if (bus.PAR_EN !== ((k % 2) == 0) || bus.PAR_TYP !== (k < 2)) $display("FAIL rr_par%0d: got en=%b typ=%b", k, bus.PAR_EN, bus.PAR_TYP); else passes++;
            bus.req[k] = 1'b0;
            bus.tx_busy = 1'b1;
            tick();
            tick();
            tick();
            checks++; if (bus.Data_valid !== 1'b0) $display("FAIL rr_dv_while_busy%0d: got %b want 0", k, bus.Data_valid); else passes++;
            bus.tx_busy = 1'b0;
            tick();
            checks++; if (bus.Data_valid !== 1'b0 || bus.arb_busy !== 1'b0) $display("FAIL rr_gap%0d: got dv=%b busy=%b want 0/0", k, bus.Data_valid, bus.arb_busy); else passes++;
        end
    endtask

    task automatic test_fairness();
        do_reset();
        bus.req = 4'b0001;
        bus.req_data = 32'h0077_0055;
        bus.req_par_en = '0;
        bus.req_par_typ = '0;
        tick();
        checks++; if (bus.grant_id !== 2'd0 || bus.P_DATA !== 8'h55) $display("FAIL fair_first: got id=%0d data=%h want 0/55", bus.grant_id, bus.P_DATA); else passes++;
        bus.tx_busy = 1'b1;
        tick();
        bus.req = 4'b0101;
        tick();
        bus.tx_busy = 1'b0;
        tick();
        tick();
        checks++; if (bus.grant_id !== 2'd2 || bus.ack !== 4'b0100 || bus.P_DATA !== 8'h77) $display("FAIL fair_second: got id=%0d ack=%b data=%h want 2/0100/77", bus.grant_id, bus.ack, bus.P_DATA); else passes++;
        bus.req = 4'b0001;
        bus.tx_busy = 1'b1;
        tick();
        tick();
        bus.tx_busy = 1'b0;
        tick();
        tick();
        checks++; if (bus.grant_id !== 2'd0 || bus.ack !== 4'b0001) $display("FAIL fair_third: got id=%0d ack=%b want 0/0001", bus.grant_id, bus.ack); else passes++;
        bus.tx_busy = 1'b1;
        bus.req = '0;
        tick();
        tick();
        bus.tx_busy = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bus.req = 4'b0100;
        bus.req_data = 32'h0099_0011;
        tick();
        checks++; if (bus.Data_valid !== 1'b1 || bus.grant_id !== 2'd2) $display("FAIL to_launch: got dv=%b id=%0d want 1/2", bus.Data_valid, bus.grant_id); else passes++;
        bus.req = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (bus.err_timeout !== 1'b0 || bus.arb_busy !== 1'b1) $display("FAIL to_early%0d: got err=%b busy=%b want 0/1", k, bus.err_timeout, bus.arb_busy); else passes++;
        end
        tick();
        checks++; if (bus.err_timeout !== 1'b1 || bus.arb_busy !== 1'b0) $display("FAIL to_pulse: got err=%b busy=%b want 1/0", bus.err_timeout, bus.arb_busy); else passes++;
        tick();
        checks++; if (bus.err_timeout !== 1'b0) $display("FAIL to_pulse_width: got %b want 0", bus.err_timeout); else passes++;
        checks++; if (bus.Data_valid !== 1'b1 || bus.ack !== 4'b0001 || bus.P_DATA !== 8'h11) $display("FAIL to_next: got dv=%b ack=%b data=%h want 1/0001/11", bus.Data_valid, bus.ack, bus.P_DATA); else passes++;
    endtask

    task automatic test_reset_mid_frame();
        bus.req = '0;
        bus.tx_busy = 1'b1;
        tick();
        tick();
        checks++; if (bus.arb_busy !== 1'b1) $display("FAIL rst_mid_pre: got %b want 1", bus.arb_busy); else passes++;
        RST = 1'b1;
        bus.tx_busy = 1'b0;
        bus.req = 4'b1111;
        bus.req_data = 32'hDDCC_BBAA;
        tick();
        checks++; if (bus.Data_valid !== 1'b0 || bus.ack !== 4'b0000) $display("FAIL rst_mid_out: got dv=%b ack=%b want 0/0000", bus.Data_valid, bus.ack); else passes++;
        checks++; if (bus.arb_busy !== 1'b0 || bus.P_DATA !== 8'h00) $display("FAIL rst_mid_state: got busy=%b data=%h want 0/00", bus.arb_busy, bus.P_DATA); else passes++;
        RST = 1'b0;
        tick();
        checks++; if (bus.ack !== 4'b0001 || bus.P_DATA !== 8'hAA) $display("FAIL rst_mid_first: got ack=%b data=%h want 0001/aa", bus.ack, bus.P_DATA); else passes++;
    endtask

    task automatic test_busy_at_entry();
        do_reset();
        bus.req = 4'b0001;
        bus.req_data = 32'h0000_003C;
        bus.tx_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.Data_valid !== 1'b0 || bus.arb_busy !== 1'b0) $display("FAIL busy_entry_hold%0d: got dv=%b busy=%b want 0/0", k, bus.Data_valid, bus.arb_busy); else passes++;
        end
        bus.tx_busy = 1'b0;
        tick();
        checks++; if (bus.Data_valid !== 1'b1 || bus.ack !== 4'b0001 || bus.P_DATA !== 8'h3C) $display("FAIL busy_entry_launch: got dv=%b ack=%b data=%h want 1/0001/3c", bus.Data_valid, bus.ack, bus.P_DATA); else passes++;
    endtask

    initial begin
        RST = 1'b1;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_timeout();
        test_reset_mid_frame();
        test_busy_at_entry();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
